// File: rtl/oq_sched_pkg.sv
// rtl/oq_sched_pkg.sv - shared types and helpers for the output-queue round-robin scheduler
package oq_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // FIFO word layout is {last, payload}
    function automatic int last_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int payload_msb(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - rotate-and-priority-encode request picker starting after ptr
module rr_priority_picker
    import oq_sched_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    localparam int SRC_W = clog2(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [SRC_W-1:0]      ptr,
    output logic                  found,
    output logic [SRC_W-1:0]      index
);

    logic [SRC_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = NUM_QUEUES; i >= 1; i--) begin
            cand = SRC_W'((int'(ptr) + i) % NUM_QUEUES);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/oq_fifo_rr_scheduler.sv
// rtl/oq_fifo_rr_scheduler.sv - packet-granular round-robin drain of fallthrough FIFOs into one registered output
module oq_fifo_rr_scheduler
    import oq_sched_pkg::*;
#(
    parameter int NUM_QUEUES = 4,
    parameter int DATA_WIDTH = 64,
    localparam int SRC_W = clog2(NUM_QUEUES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_QUEUES*(DATA_WIDTH+1)-1:0] fifo_dout,
    input  logic [NUM_QUEUES-1:0]               fifo_empty,
    output logic [NUM_QUEUES-1:0]               fifo_rd_en,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic                                out_last,
    output logic [SRC_W-1:0]                    out_src,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                busy,
    output logic                                pkt_done
);

    localparam int WORD_W      = DATA_WIDTH + 1;
    localparam int LAST_BIT    = last_bit(DATA_WIDTH);
    localparam int PAYLOAD_MSB = payload_msb(DATA_WIDTH);

    state_t           state, state_nxt;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic             pick_found;
    logic [SRC_W-1:0] pick_index;
    logic [WORD_W-1:0] words [NUM_QUEUES];
    logic [WORD_W-1:0] sel_word;
    logic             load_ok;
    logic             pop;

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_unpack
        assign words[g] = fifo_dout[g*WORD_W +: WORD_W];
    end

    rr_priority_picker #(
        .NUM_QUEUES(NUM_QUEUES)
    ) u_picker (
        .req  (~fifo_empty),
        .ptr  (rr_ptr),
        .found(pick_found),
        .index(pick_index)
    );

    // The output register can take a new word in the same cycle the held one drains.
    assign load_ok  = !out_valid || out_ready;
    assign sel_word = words[grant];
    assign pop      = (state == XFER) && !fifo_empty[grant] && load_ok;
    assign busy     = (state == XFER);
    assign pkt_done = pop && sel_word[LAST_BIT];

    always_comb begin
        fifo_rd_en = '0;
        if (pop) begin
            fifo_rd_en[grant] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = XFER;
            XFER:    if (pkt_done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rr_ptr starts at the last queue so queue 0 is first in line after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            rr_ptr    <= SRC_W'(NUM_QUEUES - 1);
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (state == IDLE && pick_found) begin
                grant <= pick_index;
            end
            if (pkt_done) begin
                rr_ptr <= grant;
            end
            if (pop) begin
                out_data  <= sel_word[PAYLOAD_MSB:0];
                out_last  <= sel_word[LAST_BIT];
                out_src   <= grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_oq_fifo_rr_scheduler.sv
// tb/tb_oq_fifo_rr_scheduler.sv - scoreboard bench for the round-robin output-queue scheduler
module tb_oq_fifo_rr_scheduler;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int W  = DW + 1;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ*W-1:0]   fifo_dout;
    logic [NQ-1:0]     fifo_empty;
    logic [NQ-1:0]     fifo_rd_en;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [SW-1:0]     out_src;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              pkt_done;

    logic [W-1:0]      fq [NQ][$];
    logic [SW+W-1:0]   exp_q [$];
    int                acc_cyc [$];
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    oq_fifo_rr_scheduler #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .pkt_done  (pkt_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NQ; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fifo_dout[i*W +: W] = (fq[i].size() == 0) ? '0 : fq[i][0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fifo_put(input int q, input logic last, input logic [DW-1:0] data);
        fq[q].push_back({last, data});
    endtask

    task automatic expect_word(input logic [SW-1:0] src, input logic last, input logic [DW-1:0] data);
        exp_q.push_back({src, last, data});
    endtask

    task automatic push_pkt(input int q, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            fifo_put(q, k == n - 1, base + DW'(k));
            expect_word(SW'(q), k == n - 1, base + DW'(k));
        end
        refresh();
    endtask

    task automatic do_reset(input bit clr_fifos);
        reset = 1'b1;
        exp_q.delete();
        acc_cyc.delete();
        if (clr_fifos) begin
            for (int i = 0; i < NQ; i++) fq[i].delete();
        end
        refresh();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // FIFO model: pops what the DUT requested at this edge, then presents the new head.
    always begin : fifo_model
        logic [NQ-1:0] pv;
        @(posedge clk);
        pv = fifo_rd_en;
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (pv[i]) begin
                check("rd_on_empty", fq[i].size() == 0, 0);
                if (fq[i].size() != 0) void'(fq[i].pop_front());
            end
        end
        refresh();
    end

    always @(negedge clk) begin : monitor
        logic [SW+W-1:0] e;
        if (!reset) begin
            check("rd_onehot0", $onehot0(fifo_rd_en), 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_src, out_last, out_data}, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_src, out_last, out_data}, e);
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        fifo_dout = '0;
        refresh();
        do_reset(1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_regs", {out_src, out_last, out_data}, 0);
        check("rst_busy_done", {busy, pkt_done}, 0);
        check("rst_rd_en", fifo_rd_en, 0);

        // 3-word packet in FIFO0: grant at edge 1, pops in cycles 2..4
        push_pkt(0, 3, 64'h1000);
        tick();
        check("t1_busy", busy, 1);
        check("t1_rd_c2", fifo_rd_en, 4'b0001);
        check("t1_valid_c2", out_valid, 0);
        tick();
        check("t1_rd_c3", fifo_rd_en, 4'b0001);
        check("t1_valid_c3", {out_valid, out_src}, {1'b1, 2'd0});
        check("t1_done_c3", pkt_done, 0);
        tick();
        check("t1_done_c4", {pkt_done, fifo_rd_en}, {1'b1, 4'b0001});
        tick();
        check("t1_after", {busy, pkt_done, fifo_rd_en, out_valid}, {1'b0, 1'b0, 4'b0000, 1'b1});
        drain("t1_drain");

        // four 2-word packets loaded at once: order 0,1,2,3 with one bubble between
        do_reset(1);
        for (int q = 0; q < NQ; q++) push_pkt(q, 2, 64'h2000 + 64'(q * 16));
        drain("t2_drain");
        check("t2_count", acc_cyc.size(), 8);
        if (acc_cyc.size() == 8) begin
            check("t2_b2b", acc_cyc[1] - acc_cyc[0], 1);
            check("t2_gap01", acc_cyc[2] - acc_cyc[0], 3);
            check("t2_gap12", acc_cyc[4] - acc_cyc[2], 3);
            check("t2_gap23", acc_cyc[6] - acc_cyc[4], 3);
        end
        // rr_ptr now 3, so queue 0 beats queue 3
        push_pkt(0, 1, 64'h2100);
        push_pkt(3, 1, 64'h2200);
        drain("t2_wrap_drain");

        // back-pressure mid-packet
        do_reset(1);
        push_pkt(2, 4, 64'h3000);
        tick();
        tick();
        check("t3_first_valid", {out_valid, out_data}, {1'b1, 64'h3000});
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_stall_rd", fifo_rd_en, 0);
            check("t3_stall_out", {out_valid, out_data}, {1'b1, 64'h3000});
        end
        out_ready = 1'b1;
        drain("t3_drain");

        // granted FIFO1 runs dry mid-packet while FIFO3 waits
        do_reset(1);
        fifo_put(1, 1'b0, 64'h4000);
        expect_word(2'd1, 1'b0, 64'h4000);
        expect_word(2'd1, 1'b0, 64'h4001);
        expect_word(2'd1, 1'b1, 64'h4002);
        push_pkt(3, 1, 64'h4100);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_hold", {busy, fifo_rd_en, out_valid}, {1'b1, 4'b0000, 1'b0});
        end
        fifo_put(1, 1'b0, 64'h4001);
        fifo_put(1, 1'b1, 64'h4002);
        refresh();
        drain("t4_drain");

        // reset during word 2 of 4; remainder stays queued
        do_reset(1);
        push_pkt(2, 4, 64'h5000);
        tick();
        tick();
        check("t5_pre_rd", fifo_rd_en, 4'b0100);
        reset = 1'b1;
        #1;
        check("t5_async", {out_valid, busy, fifo_rd_en}, 0);
        exp_q.delete();
        acc_cyc.delete();
        push_pkt(0, 2, 64'h5100);
        expect_word(2'd2, 1'b0, 64'h5001);
        expect_word(2'd2, 1'b0, 64'h5002);
        expect_word(2'd2, 1'b1, 64'h5003);
        tick();
        tick();
        reset = 1'b0;
        drain("t5_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oq_fifo_rr_scheduler.md
Name: oq_fifo_rr_scheduler

Overview:
- Packet-aware round-robin scheduler in the SRAM output-queue datapath.
- Reads the read side of NUM_QUEUES fallthrough small FIFOs. Each FIFO word is {last, data}.
- Grants one FIFO at a time and holds the grant until that packet's last word is popped.
- Forwards words through one registered output stage with a valid/ready handshake toward the SRAM write engine.
- Arbitration is packet-granular, never word-interleaved.

Parameters:
- NUM_QUEUES, 4, number of input FIFOs; legal range 2..16.
- DATA_WIDTH, 64, payload bits per word. Each FIFO word is DATA_WIDTH+1 bits, MSB = last.
- SRC_W, derived localparam = clog2(NUM_QUEUES), width of source index.

Ports:
- clk  in  1  single clock; FIFO read side and output both run on it.
- reset  in  1  asynchronous, active-high reset.
- fifo_dout  in  NUM_QUEUES*(DATA_WIDTH+1)  FIFO i word at slice i; valid whenever fifo_empty[i]=0 (fallthrough).
- fifo_empty  in  NUM_QUEUES  per-FIFO empty.
- fifo_rd_en  out  NUM_QUEUES  per-FIFO pop, one-hot or zero.
- out_data  out  DATA_WIDTH  registered payload.
- out_last  out  1  registered end-of-packet flag.
- out_src  out  SRC_W  index of the FIFO the word came from.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high while state=XFER.
- pkt_done  out  1  one-cycle pulse when a last word is popped.

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, rr_ptr=NUM_QUEUES-1 (so queue 0 has priority first), out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, pkt_done=0, fifo_rd_en=0.
- load_ok = !out_valid || out_ready. The output register accepts a new word in the same cycle the held one drains.
- IDLE:
  - Scan fifo_empty starting at rr_ptr+1 mod NUM_QUEUES; pick the first non-empty FIFO.
  - If one is found: grant<=index, state<=XFER. No pop occurs this cycle (one-cycle arbitration bubble).
  - If none is found: stay in IDLE.
- XFER:
  - pop = !fifo_empty[grant] && load_ok.
  - fifo_rd_en[grant]=pop, combinational. All other rd_en bits stay 0.
  - On pop: out_data/out_last <= selected FIFO word; out_src<=grant; out_valid<=1.
  - On pop with last=1: pkt_done=1 (combinational with pop), rr_ptr<=grant, state<=IDLE.
  - If no pop and out_ready=1: out_valid<=0.
- Latency: FIFO non-empty in IDLE -> grant at edge 1 -> first pop in cycle 2 -> out_valid high after edge 2.
- Steady throughput: 1 word/cycle within a packet. 1 idle cycle between packets.
- Boundary conditions:
  - Granted FIFO goes empty mid-packet: hold grant, stall, no preemption. Other FIFOs wait.
  - out_ready low: no pop. out_valid and out_* stay stable until accepted.
  - Single-word packet (last on first word): XFER lasts one pop cycle, then IDLE.
  - All FIFOs non-empty: service order is strictly rr_ptr+1, +2, … with wrap from NUM_QUEUES-1 to 0.
  - Reset mid-packet: everything returns to reset values immediately. The partial packet remainder stays in its FIFO; the scheduler does not flush it.
  - A FIFO going non-empty in the same cycle IDLE scans: it is seen only if fifo_empty is already low that cycle.

Decomposition:
- Shared package oq_sched_pkg:
  - state encoding (IDLE, XFER)
  - function clog2
  - word-field constants: LAST_BIT = DATA_WIDTH, PAYLOAD_MSB = DATA_WIDTH-1.
- One sub-module, rr_priority_picker. Combinational, parameterised by NUM_QUEUES.
  - Inputs: request vector (~fifo_empty), rr_ptr.
  - Outputs: found, index.
  - Rotate-and-priority-encode.

Test Plan:
- Reset then FIFO0 holds 3-word packet (last on word 3), out_ready=1 -> grant 0 at edge 1; rd_en[0] high cycles 2-4; out_valid high 3 cycles, out_src=0; pkt_done on cycle 4; busy drops after.
- FIFOs 0-3 each hold one 2-word packet -> output order src 0,1,2,3 with a 1-cycle gap between packets; rr_ptr ends at 3.
- FIFO2 mid-packet, out_ready low for 4 cycles -> no rd_en, out_data held constant, out_valid=1; resumes same word order afterward.
- Granted FIFO1 empties after word 1 of 3 while FIFO3 is non-empty -> grant stays 1; FIFO3 is not served until FIFO1's last word pops.
- Reset asserted during word 2 of 4 -> out_valid, busy and rd_en drop asynchronously. After release, the next grant goes to queue 0 if non-empty.
